// File: rtl/allgates_sweep_capture_pkg.sv
// Shared definitions for the all-gates sweep/capture stage.
// Holds the response width, the bit positions of each gate output in a
// response word, the vector count and the FSM state encoding.
package allgates_pkg;

  localparam int RESP_W = 13;
  localparam int NVEC   = 16;

  // Bit position of each netlist gate output inside a response word.
  localparam int BIT_NOT    = 0;
  localparam int BIT_AND    = 1;
  localparam int BIT_NAND   = 2;
  localparam int BIT_ANDNOT = 3;
  localparam int BIT_OR     = 4;
  localparam int BIT_NOR    = 5;
  localparam int BIT_ORNOT  = 6;
  localparam int BIT_XOR    = 7;
  localparam int BIT_XNOR   = 8;
  localparam int BIT_AOI3   = 9;
  localparam int BIT_OAI3   = 10;
  localparam int BIT_AOI4   = 11;
  localparam int BIT_OAI4   = 12;

  // Sweep FSM states, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRIVE  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/allgates_sweep_capture_if.sv
// Bus between the sweep/capture stage and its surroundings.
//   start/busy/done      : sweep control and status
//   stim/resp            : stimulus to and response from the gate netlist
//   rd_addr/rd_data/rd_valid : truth-table read port
// slave  = the capture stage, master = host/bench side.
interface allgates_sweep_capture_if;
  import allgates_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [3:0]        stim;
  logic [RESP_W-1:0] resp;
  logic [3:0]        rd_addr;
  logic [RESP_W-1:0] rd_data;
  logic              rd_valid;

  modport slave  (input  start, resp, rd_addr,
                  output busy, done, stim, rd_data, rd_valid);
  modport master (output start, resp, rd_addr,
                  input  busy, done, stim, rd_data, rd_valid);

endinterface

// File: rtl/allgates_sweep_capture_tt_buffer.sv
// 16-entry truth-table buffer: one write port, registered read port
// (1-cycle latency, read-before-write) and a per-entry valid bit.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr_valid   : clear all valid bits (sweep restart)
//   wr_en/wr_addr/wr_data : response write
//   rd_addr     : read index; rd_data/rd_valid registered results
module tt_buffer
  import allgates_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_valid,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [RESP_W-1:0] wr_data,
  input  logic [3:0]        rd_addr,
  output logic [RESP_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [RESP_W-1:0] mem_r [NVEC];
  logic [NVEC-1:0]   valid_r;
  logic [RESP_W-1:0] rd_data_r;
  logic              rd_valid_r;

  // Storage array; contents are deliberately not reset, but a write is
  // suppressed on a reset edge so an aborted sweep leaves no new data.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Valid bits: cleared on reset or restart, set as each entry is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= {NVEC{1'b0}};
    end else if (clr_valid) begin
      valid_r <= {NVEC{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_addr] <= 1'b1;
    end
  end

  // Registered read; sees pre-write contents when addresses collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_r  <= {RESP_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_data_r  <= mem_r[rd_addr];
      rd_valid_r <= valid_r[rd_addr];
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: rtl/allgates_sweep_capture.sv
// Exhaustive stimulus/capture stage for the 4-input all-gates netlist.
// Drives every 4-bit vector in order on stim, waits SETTLE cycles, then
// stores the netlist response in a 16-entry truth table readable via
// rd_addr/rd_data/rd_valid.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : control, stimulus/response and read port (slave side)
//   SETTLE     : cycles from stim update to response sample (1..15)
module allgates_sweep_capture
  import allgates_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  allgates_sweep_capture_if.slave bus
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_r;
  logic [3:0] vec_r;
  logic [3:0] cnt_r;
  logic [3:0] stim_r;
  logic       busy_r;
  logic       done_r;
  logic       wr_en_s;
  logic       clr_valid_s;

  // Buffer write strobe and restart-time valid clear.
  always_comb begin
    wr_en_s     = 1'b0;
    clr_valid_s = 1'b0;
    if ((state_r == ST_SAMPLE) && (cnt_r == 4'd0)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.start) begin
      clr_valid_s = 1'b1;
    end else begin
      clr_valid_s = 1'b0;
    end
  end

  // Sweep FSM with vector and settle counters; stim only moves when
  // entering DRIVE, so each vector holds for SETTLE+1 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      vec_r   <= 4'd0;
      cnt_r   <= 4'd0;
      stim_r  <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            vec_r   <= 4'd0;
            stim_r  <= 4'd0;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          cnt_r   <= SETTLE_M1;
          state_r <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (vec_r == 4'd15) begin
            // Last vector captured: stop without wrapping, stim holds 15.
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            vec_r   <= vec_r + 4'd1;
            stim_r  <= vec_r + 4'd1;
            state_r <= ST_DRIVE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  tt_buffer u_tt_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_valid (clr_valid_s),
    .wr_en     (wr_en_s),
    .wr_addr   (vec_r),
    .wr_data   (bus.resp),
    .rd_addr   (bus.rd_addr),
    .rd_data   (bus.rd_data),
    .rd_valid  (bus.rd_valid)
  );

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.stim = stim_r;

endmodule

// File: tb/tb_allgates_sweep_capture.sv
// Self-checking bench: two capture stages (SETTLE=1 and SETTLE=3) each
// wrapped around a behavioural all-gates netlist; tables are compared
// against gate equations evaluated directly from each vector.
module tb_allgates_sweep_capture;
  import allgates_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  allgates_sweep_capture_if if1 ();
  allgates_sweep_capture_if if3 ();

  allgates_sweep_capture #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  allgates_sweep_capture #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int         n_vec = 0;
  int         n_fail = 0;
  logic       inv1 = 1'b0;
  int         xcnt3 = 0;
  logic [3:0] prev3 = 4'd0;

  // Reference all-gates netlist (a=v[0], b=v[1], c=v[2], d=v[3]).
  function automatic logic [RESP_W-1:0] gate_model(logic [3:0] v);
    logic a, b, c, d;
    logic [RESP_W-1:0] r;
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    r[0]  = !a;
    r[1]  = a && b;
    r[2]  = !(a && b);
    r[3]  = a && !b;
    r[4]  = a || b;
    r[5]  = !(a || b);
    r[6]  = a || !b;
    r[7]  = a != b;
    r[8]  = a == b;
    r[9]  = !((a && b) || c);
    r[10] = !((a || b) && c);
    r[11] = !((a && b) || (c && d));
    r[12] = !((a || b) && (c || d));
    return r;
  endfunction

  assign if1.resp = gate_model(if1.stim) ^ (inv1 ? 13'h1FFF : 13'h0000);
  assign if3.resp = (xcnt3 > 0) ? {RESP_W{1'bx}} : gate_model(if3.stim);

  // Netlist of the SETTLE=3 stage shows X for two cycles after stim moves.
  initial forever begin
    @(posedge clk); #1;
    if (if3.stim !== prev3) begin
      prev3 = if3.stim;
      xcnt3 = 2;
    end else if (xcnt3 > 0) begin
      xcnt3 = xcnt3 - 1;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_start(bit s3, logic v);
    if (s3) if3.start = v; else if1.start = v;
  endtask
  task automatic set_addr(bit s3, logic [3:0] a);
    if (s3) if3.rd_addr = a; else if1.rd_addr = a;
  endtask
  function automatic logic get_busy(bit s3);  return s3 ? if3.busy : if1.busy; endfunction
  function automatic logic get_done(bit s3);  return s3 ? if3.done : if1.done; endfunction
  function automatic logic get_valid(bit s3); return s3 ? if3.rd_valid : if1.rd_valid; endfunction
  function automatic logic [3:0] get_stim(bit s3); return s3 ? if3.stim : if1.stim; endfunction
  function automatic logic [RESP_W-1:0] get_data(bit s3); return s3 ? if3.rd_data : if1.rd_data; endfunction

  // Start pulse, then wait for done while checking latency and stim hold time.
  task automatic run_sweep(bit s3, int settle, int exp_cycles, string tag);
    int n, run;
    logic [3:0] cur;
    set_start(s3, 1'b1);
    tick();
    n = 1;
    set_start(s3, 1'b0);
    chk({tag, "_busy_hi"}, 32'(get_busy(s3)), 32'd1);
    chk({tag, "_done_lo"}, 32'(get_done(s3)), 32'd0);
    cur = get_stim(s3);
    run = 1;
    while (!get_done(s3) && n < 200) begin
      tick();
      n++;
      if (get_stim(s3) == cur) begin
        run++;
      end else begin
        chk({tag, "_hold"}, 32'(run), 32'(settle + 1));
        cur = get_stim(s3);
        run = 1;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_busy_lo"}, 32'(get_busy(s3)), 32'd0);
    chk({tag, "_stim_end"}, 32'(get_stim(s3)), 32'd15);
  endtask

  // Read every entry in random order and compare with the gate model.
  task automatic readback(bit s3, logic [RESP_W-1:0] mask, string tag);
    int order[16];
    int j, t;
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 16; i++) begin
      set_addr(s3, 4'(order[i]));
      tick();
      chk({tag, "_data"}, 32'(get_data(s3)), 32'(gate_model(4'(order[i])) ^ mask));
      chk({tag, "_valid"}, 32'(get_valid(s3)), 32'd1);
    end
  endtask

  task automatic check_all_invalid(bit s3, string tag);
    for (int i = 0; i < 16; i++) begin
      set_addr(s3, 4'(i));
      tick();
      chk(tag, 32'(get_valid(s3)), 32'd0);
    end
  endtask

  initial begin
    int n, steps, bad;
    logic [3:0] prev, s;

    // Reset and idle
    if1.start = 1'b0; if3.start = 1'b0;
    if1.rd_addr = 4'd0; if3.rd_addr = 4'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_rd_data1", 32'(if1.rd_data), 32'd0);
    chk("rst_rd_data3", 32'(if3.rd_data), 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    for (int k = 0; k < 2; k++) begin
      chk("idle_stim", 32'(get_stim(k[0])), 32'd0);
      chk("idle_busy", 32'(get_busy(k[0])), 32'd0);
      chk("idle_done", 32'(get_done(k[0])), 32'd0);
      check_all_invalid(k[0], "idle_valid");
    end

    // SETTLE=1 sweep with directed and random-order readback
    run_sweep(1'b0, 1, 33, "s1");
    if1.rd_addr = 4'd0;  tick(); chk("s1_addr0",  32'(if1.rd_data), 32'h1F65);
    if1.rd_addr = 4'd1;  tick(); chk("s1_addr1",  32'(if1.rd_data), 32'h1EDC);
    if1.rd_addr = 4'd15; tick(); chk("s1_addr15", 32'(if1.rd_data), 32'h0152);
    readback(1'b0, 13'h0000, "s1_rb");

    // SETTLE=3 sweep with X on resp right after each stim change
    repeat (int'($urandom_range(5, 1))) tick();
    run_sweep(1'b1, 3, 65, "s3");
    readback(1'b1, 13'h0000, "s3_rb");

    // start held high through a whole sweep: one monotonic pass only
    if1.start = 1'b1;
    n = 0; steps = 0; bad = 0; prev = 4'd0;
    tick(); n++;
    chk("hold_first_stim", 32'(if1.stim), 32'd0);
    while (!if1.done && n < 200) begin
      tick(); n++;
      s = if1.stim;
      if (s == prev + 4'd1) steps++;
      else if (s != prev) bad++;
      prev = s;
    end
    if1.start = 1'b0;
    chk("hold_latency", 32'(n), 32'd33);
    chk("hold_monotonic", 32'(bad), 32'd0);
    chk("hold_steps", 32'(steps), 32'd15);
    repeat (4) tick();
    chk("hold_no_restart_done", 32'(if1.done), 32'd1);
    chk("hold_no_restart_stim", 32'(if1.stim), 32'd15);

    // Restart from DONE with new data; rd_addr=5 observes the collision
    inv1 = 1'b1;
    if1.rd_addr = 4'd5;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    tick();
    chk("restart_valid_clr", 32'(if1.rd_valid), 32'd0);
    n = 0;
    while (if1.stim != 4'd6 && n < 100) begin tick(); n++; end
    chk("coll_reached", 32'(if1.stim), 32'd6);
    chk("coll_old_data", 32'(if1.rd_data), 32'(gate_model(4'd5)));
    chk("coll_old_valid", 32'(if1.rd_valid), 32'd0);
    tick();
    chk("coll_new_data", 32'(if1.rd_data), 32'(gate_model(4'd5) ^ 13'h1FFF));
    chk("coll_new_valid", 32'(if1.rd_valid), 32'd1);
    n = 0;
    while (!if1.done && n < 100) begin tick(); n++; end
    chk("coll_done", 32'(if1.done), 32'd1);
    readback(1'b0, 13'h1FFF, "inv_rb");

    // Reset mid-sweep at vector 7, then a clean sweep
    inv1 = 1'b0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    n = 0;
    while (if1.stim != 4'd7 && n < 100) begin tick(); n++; end
    chk("abort_reached", 32'(if1.stim), 32'd7);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(if1.busy), 32'd0);
    chk("abort_stim", 32'(if1.stim), 32'd0);
    chk("abort_done", 32'(if1.done), 32'd0);
    chk("abort_valid", 32'(if1.rd_valid), 32'd0);
    chk("abort_data", 32'(if1.rd_data), 32'd0);
    rst_n = 1'b1;
    check_all_invalid(1'b0, "abort_valid_all");
    run_sweep(1'b0, 1, 33, "s1b");
    readback(1'b0, 13'h0000, "s1b_rb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
